reg_window_ctrl: RTL

Sequencer for the 4-window, 8-entry overlapped register file. It owns the current window pointer and services call/return requests from the datapath. When a call would overwrite a live window it spills the oldest window's two private registers to a memory stack; when a return needs a spilled caller window it refills them. While busy it takes over the register file's read-1 and write ports and stalls the datapath.

---
 rtl/reg_window_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/reg_window_ctrl.sv
// Window-pointer sequencer for a 4-window, 8-entry overlapped register file.
// Optional REGWIN_STATS_EN adds saturating spill/fill counters.
module reg_window_ctrl #(
  parameter logic [15:0] SPILL_BASE   = 16'h0F00,
  parameter int          SPILL_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call,
  input  logic        ret,
  output logic        busy,
  output logic        err,
  input  logic [1:0]  dpReadReg1,
  input  logic [1:0]  dpWriteReg,
  input  logic [15:0] dpWriteData,
  input  logic        dpWriteEn,
  output logic [1:0]  rfWindow,
  output logic [1:0]  rfReadReg1,
  output logic [1:0]  rfWriteReg,
  output logic [15:0] rfWriteData,
  output logic        rfWriteEn,
  input  logic [15:0] rfReadData1,
  output logic        memReq,
  output logic        memWe,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  input  logic        memAck,
  output logic [2:0]  dbgState
`ifdef REGWIN_STATS_EN
  ,
  output logic [15:0] spillCount,
  output logic [15:0] fillCount
`endif
);

  // Handshake: memReq/memWe/memAddr/memWdata stay stable from the first
  // SP_MEM/FL_MEM cycle until memAck is sampled high; memAck is ignored
  // in every other state.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SP_ADDR = 3'd1,
    SP_MEM  = 3'd2,
    SP_DONE = 3'd3,
    FL_MEM  = 3'd4,
    FL_WR   = 3'd5,
    FL_DONE = 3'd6
  } state_t;

  localparam logic [15:0] SP_LIMIT = 16'(2 * SPILL_FRAMES);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cwp, w_cwp_nxt;
  logic [1:0]  r_depth, w_depth_nxt;
  logic [15:0] r_sp, w_sp_nxt;
  logic        r_k, w_k_nxt;
  logic [15:0] r_fill_data, w_fill_nxt;
  logic        r_err, w_err_nxt;

  logic [1:0]  w_win, w_rd_sel, w_wr_sel;
  logic [15:0] w_wr_data;
  logic        w_wr_en;
  logic        w_mem_req, w_mem_we;
  logic [15:0] w_mem_addr, w_mem_wdata;
  logic [15:0] w_k16;

  assign w_k16 = {15'd0, r_k};

  always_comb begin
    w_state_nxt = r_state;
    w_cwp_nxt   = r_cwp;
    w_depth_nxt = r_depth;
    w_sp_nxt    = r_sp;
    w_k_nxt     = r_k;
    w_fill_nxt  = r_fill_data;
    w_err_nxt   = 1'b0;
    w_win       = r_cwp;
    w_rd_sel    = dpReadReg1;
    w_wr_sel    = dpWriteReg;
    w_wr_data   = dpWriteData;
    w_wr_en     = dpWriteEn;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = 16'd0;
    w_mem_wdata = 16'd0;

    // Any non-idle state owns the register file ports outright.
    if (r_state != IDLE) begin
      w_rd_sel  = 2'd0;
      w_wr_sel  = 2'd0;
      w_wr_data = 16'd0;
      w_wr_en   = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (call && ret) begin
          w_err_nxt = 1'b1;
        end else if (call) begin
          if (r_depth != 2'd3) begin
            w_cwp_nxt   = r_cwp + 2'd1;
            w_depth_nxt = r_depth + 2'd1;
          end else if (r_sp < SP_LIMIT) begin
            w_state_nxt = SP_ADDR;
            w_k_nxt     = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (ret) begin
          if (r_depth != 2'd1) begin
            w_cwp_nxt   = r_cwp - 2'd1;
            w_depth_nxt = r_depth - 2'd1;
          end else if (r_sp != 16'd0) begin
            w_state_nxt = FL_MEM;
            w_k_nxt     = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      // Read select is registered inside the register file, so the select
      // is presented one cycle ahead of the memory write.
      SP_ADDR: begin
        w_win       = r_cwp - 2'd2;
        w_rd_sel    = {1'b0, r_k};
        w_state_nxt = SP_MEM;
      end
      SP_MEM: begin
        w_win       = r_cwp - 2'd2;
        w_rd_sel    = {1'b0, r_k};
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = SPILL_BASE + r_sp + w_k16;
        w_mem_wdata = rfReadData1;
        if (memAck) begin
          if (!r_k) begin
            w_k_nxt     = 1'b1;
            w_state_nxt = SP_ADDR;
          end else begin
            w_state_nxt = SP_DONE;
          end
        end
      end
      SP_DONE: begin
        w_sp_nxt    = r_sp + 16'd2;
        w_cwp_nxt   = r_cwp + 2'd1;
        w_state_nxt = IDLE;
      end
      FL_MEM: begin
        w_mem_req  = 1'b1;
        w_mem_addr = SPILL_BASE + r_sp - 16'd2 + w_k16;
        if (memAck) begin
          w_fill_nxt  = memRdata;
          w_state_nxt = FL_WR;
        end
      end
      FL_WR: begin
        w_win     = r_cwp - 2'd1;
        w_wr_sel  = {1'b0, r_k};
        w_wr_data = r_fill_data;
        w_wr_en   = 1'b1;
        if (!r_k) begin
          w_k_nxt     = 1'b1;
          w_state_nxt = FL_MEM;
        end else begin
          w_state_nxt = FL_DONE;
        end
      end
      FL_DONE: begin
        w_sp_nxt    = r_sp - 16'd2;
        w_cwp_nxt   = r_cwp - 2'd1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cwp       <= 2'd0;
      r_depth     <= 2'd1;
      r_sp        <= 16'd0;
      r_k         <= 1'b0;
      r_fill_data <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cwp       <= w_cwp_nxt;
      r_depth     <= w_depth_nxt;
      r_sp        <= w_sp_nxt;
      r_k         <= w_k_nxt;
      r_fill_data <= w_fill_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign busy        = (r_state != IDLE);
  assign err         = r_err;
  assign dbgState    = r_state;
  assign rfWindow    = w_win;
  assign rfReadReg1  = w_rd_sel;
  assign rfWriteReg  = w_wr_sel;
  assign rfWriteData = w_wr_data;
  assign rfWriteEn   = w_wr_en;
  assign memReq      = w_mem_req;
  assign memWe       = w_mem_we;
  assign memAddr     = w_mem_addr;
  assign memWdata    = w_mem_wdata;

`ifdef REGWIN_STATS_EN
  logic [15:0] r_spill_cnt, r_fill_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spill_cnt <= 16'd0;
      r_fill_cnt  <= 16'd0;
    end else begin
      if (r_state == SP_DONE && r_spill_cnt != 16'hFFFF)
        r_spill_cnt <= r_spill_cnt + 16'd1;
      if (r_state == FL_DONE && r_fill_cnt != 16'hFFFF)
        r_fill_cnt <= r_fill_cnt + 16'd1;
    end
  end

  assign spillCount = r_spill_cnt;
  assign fillCount  = r_fill_cnt;
`endif

endmodule
